// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART TX arbitration path
package uart_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_HEADER, ARB_PAYLOAD} arb_state_t;
  localparam logic [3:0] HDR_MAGIC = 4'hA;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);
  localparam int IW = $clog2(N);
  logic          found;
  logic [IW-1:0] idx;
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: per-packet round-robin sharing of the UART byte stream
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HEADER_EN   = 1,
  parameter int MAX_PKT_LEN = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [8*N_REQ-1:0] s_axis_tdata_i,
  input  logic [N_REQ-1:0]   s_axis_tvalid_i,
  input  logic [N_REQ-1:0]   s_axis_tlast_i,
  output logic [N_REQ-1:0]   s_axis_tready_o,
  output logic [7:0]         m_axis_tdata_o,
  output logic               m_axis_tvalid_o,
  input  logic               m_axis_tready_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o,
  output logic               trunc_o
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_PKT_LEN + 1);
  arb_state_t       state, state_nxt;
  logic [N_REQ-1:0] grant, arb_gnt;
  logic [IW-1:0]    id, rr_ptr, arb_id;
  logic [CW-1:0]    beat_cnt;
  logic             trunc, hs, rel;
  rr_arbiter #(.N(N_REQ)) u_rr (
    .req    (s_axis_tvalid_i),
    .ptr    (rr_ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );
  assign hs  = state == ARB_PAYLOAD && s_axis_tvalid_i[id] && m_axis_tready_i;
  assign rel = hs && (s_axis_tlast_i[id] || beat_cnt == CW'(MAX_PKT_LEN - 1));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ARB_IDLE;
    else         state <= state_nxt;
  end
  always_comb begin
    state_nxt = (state == ARB_IDLE)    ? (|s_axis_tvalid_i ? (HEADER_EN != 0 ? ARB_HEADER : ARB_PAYLOAD) : ARB_IDLE)
              : (state == ARB_HEADER)  ? (m_axis_tready_i ? ARB_PAYLOAD : ARB_HEADER)
              : (state == ARB_PAYLOAD) ? (rel ? ARB_IDLE : ARB_PAYLOAD)
              : ARB_IDLE;
  end
  // rr_ptr only advances on release, so an abandoned packet keeps its owner's priority slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant    <= '0;
      id       <= '0;
      rr_ptr   <= IW'(N_REQ - 1);
      beat_cnt <= '0;
      trunc    <= 1'b0;
    end else begin
      trunc    <= rel && !s_axis_tlast_i[id];
      beat_cnt <= (state == ARB_PAYLOAD) ? beat_cnt + CW'(hs) : '0;
      if (state == ARB_IDLE && |s_axis_tvalid_i) begin
        grant <= arb_gnt;
        id    <= arb_id;
      end else if (rel) begin
        grant  <= '0;
        rr_ptr <= id;
      end
    end
  end
  always_comb begin
    m_axis_tvalid_o = state == ARB_HEADER || (state == ARB_PAYLOAD && s_axis_tvalid_i[id]);
    m_axis_tdata_o  = (state == ARB_HEADER)  ? {HDR_MAGIC, 4'(id)}
                    : (state == ARB_PAYLOAD) ? s_axis_tdata_i[{id, 3'b000} +: 8]
                    : 8'h00;
    s_axis_tready_o = (state == ARB_PAYLOAD && m_axis_tready_i) ? grant : '0;
    grant_o         = grant;
    busy_o          = state != ARB_IDLE;
    trunc_o         = trunc;
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of the TX arbiter with and without headers
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid, s_tlast;
  logic        mrdy;
  logic [3:0]  rdy0, rdy1, gnt0, gnt1;
  logic [7:0]  md0, md1;
  logic        mv0, mv1, busy0, busy1, tr0, tr1;
  logic [8:0]  q[4][$];
  logic [3:0]  hold = 4'b0;
  logic        sel = 1'b0;
  logic [7:0]  got[$];
  logic [3:0]  gots[$];
  int          n_trunc = 0;
  int          pass = 0, total = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(4), .HEADER_EN(1), .MAX_PKT_LEN(64)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid),
    .s_axis_tlast_i(s_tlast), .s_axis_tready_o(rdy0), .m_axis_tdata_o(md0),
    .m_axis_tvalid_o(mv0), .m_axis_tready_i(mrdy), .grant_o(gnt0), .busy_o(busy0), .trunc_o(tr0)
  );
  uart_tx_arbiter #(.N_REQ(4), .HEADER_EN(0), .MAX_PKT_LEN(64)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid),
    .s_axis_tlast_i(s_tlast), .s_axis_tready_o(rdy1), .m_axis_tdata_o(md1),
    .m_axis_tvalid_o(mv1), .m_axis_tready_i(mrdy), .grant_o(gnt1), .busy_o(busy1), .trunc_o(tr1)
  );

  task automatic apply();
    logic [8:0] e;
    for (int k = 0; k < 4; k++) begin
      e = (q[k].size() > 0) ? q[k][0] : 9'h000;
      s_tvalid[k]       = q[k].size() > 0 && !hold[k];
      s_tdata[8*k +: 8] = e[7:0];
      s_tlast[k]        = q[k].size() > 0 && e[8];
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (sel ? (mv1 && mrdy) : (mv0 && mrdy)) begin
        got.push_back(sel ? md1 : md0);
        gots.push_back(sel ? gnt1 : gnt0);
      end
      if (sel ? tr1 : tr0) n_trunc++;
      for (int k = 0; k < 4; k++)
        if (s_tvalid[k] && (sel ? rdy1[k] : rdy0[k]) && q[k].size() > 0) void'(q[k].pop_front());
      #1 apply();
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) q[k].delete();
    hold = 4'b0;
    apply();
    repeat (2) @(negedge clk);
    got.delete();
    gots.delete();
    n_trunc = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_got(input int n, input int budget);
    int c = 0;
    while (got.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (got.size() < n) $display("FAIL wait_got: have %0d bytes, need %0d", got.size(), n);
    else pass++;
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp[$]);
    total++;
    if (got.size() !== exp.size()) $display("FAIL %s_len: got %0d bytes, expected %0d", name, got.size(), exp.size());
    else pass++;
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) $display("FAIL %s[%0d]: got %h, expected %h", name, i, got[i], exp[i]);
      else pass++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({gnt0, rdy0, md0, mv0, busy0, tr0} !== 21'd0) $display("FAIL reset_out0: got %h, expected 0", {gnt0, rdy0, md0, mv0, busy0, tr0});
    else pass++;
    total++;
    if ({gnt1, rdy1, md1, mv1, busy1, tr1} !== 21'd0) $display("FAIL reset_out1: got %h, expected 0", {gnt1, rdy1, md1, mv1, busy1, tr1});
    else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy0, gnt0, mv0} !== 6'd0) $display("FAIL reset_idle: got %h, expected 0", {busy0, gnt0, mv0});
    else pass++;
  endtask

  task automatic test_single();
    logic [7:0] exp[$];
    do_reset();
    q[1].push_back({1'b0, 8'h11});
    q[1].push_back({1'b1, 8'h22});
    apply();
    @(negedge clk);
    total++;
    if ({gnt0, busy0, md0} !== {4'b0010, 1'b1, 8'hA1}) $display("FAIL single_grant: got %h, expected %h", {gnt0, busy0, md0}, {4'b0010, 1'b1, 8'hA1});
    else pass++;
    wait_got(3, 20);
    exp = '{8'hA1, 8'h11, 8'h22};
    check_bytes("single", exp);
    for (int i = 0; i < gots.size(); i++) begin
      total++;
      if (gots[i] !== 4'b0010) $display("FAIL single_gnt[%0d]: got %b, expected 0010", i, gots[i]);
      else pass++;
    end
    @(negedge clk);
    total++;
    if ({busy0, gnt0} !== 5'd0) $display("FAIL single_idle: got %h, expected 0", {busy0, gnt0});
    else pass++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp[$];
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) q[k].push_back({1'b1, 8'(k * 16 + r)});
    apply();
    wait_got(16, 100);
    for (int i = 0; i < 16; i++)
      exp.push_back((i % 2 == 0) ? 8'(8'hA0 + (i % 8) / 2) : 8'(((i % 8) / 2) * 16 + i / 8));
    check_bytes("rr", exp);
  endtask

  task automatic test_truncate();
    logic [7:0] exp[$];
    do_reset();
    for (int i = 0; i < 70; i++) q[2].push_back({1'b0, 8'(i)});
    apply();
    wait_got(72, 300);
    repeat (5) @(negedge clk);
    exp.push_back(8'hA2);
    for (int i = 0; i < 64; i++) exp.push_back(8'(i));
    exp.push_back(8'hA2);
    for (int i = 64; i < 70; i++) exp.push_back(8'(i));
    check_bytes("trunc", exp);
    total++;
    if (n_trunc !== 1) $display("FAIL trunc_pulses: got %0d, expected 1", n_trunc);
    else pass++;
    total++;
    if ({busy0, gnt0} !== {1'b1, 4'b0100}) $display("FAIL trunc_hold: got %h, expected %h", {busy0, gnt0}, {1'b1, 4'b0100});
    else pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[$];
    logic [7:0] d;
    logic       ok = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) q[1].push_back({i == 7, 8'(8'h30 + i)});
    apply();
    wait_got(3, 20);
    mrdy = 1'b0;
    #1 d = md0;
    total++;
    if (d !== 8'h32) $display("FAIL bp_data: got %h, expected 32", d);
    else pass++;
    repeat (20) begin
      @(negedge clk);
      if (md0 !== d || mv0 !== 1'b1 || rdy0 !== 4'b0) ok = 1'b0;
    end
    total++;
    if (!ok || got.size() != 3) $display("FAIL bp_stable: got ok=%0b bytes=%0d, expected ok=1 bytes=3", ok, got.size());
    else pass++;
    mrdy = 1'b1;
    wait_got(9, 30);
    repeat (3) @(negedge clk);
    exp.push_back(8'hA1);
    for (int i = 0; i < 8; i++) exp.push_back(8'(8'h30 + i));
    check_bytes("bp", exp);
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp[$];
    do_reset();
    q[1].push_back({1'b1, 8'h41});
    apply();
    wait_got(2, 20);
    for (int i = 0; i < 5; i++) q[2].push_back({i == 4, 8'(8'h50 + i)});
    apply();
    wait_got(6, 30);
    rst_n = 1'b0;
    #1;
    total++;
    if ({gnt0, rdy0, md0, mv0, busy0, tr0} !== 21'd0) $display("FAIL midrst_out: got %h, expected 0", {gnt0, rdy0, md0, mv0, busy0, tr0});
    else pass++;
    for (int k = 0; k < 4; k++) q[k].delete();
    apply();
    repeat (2) @(negedge clk);
    got.delete();
    gots.delete();
    rst_n = 1'b1;
    q[3].push_back({1'b1, 8'h63});
    q[0].push_back({1'b1, 8'h60});
    apply();
    wait_got(4, 30);
    exp = '{8'hA0, 8'h60, 8'hA3, 8'h63};
    check_bytes("midrst", exp);
  endtask

  task automatic test_gap_no_header();
    logic [7:0] exp[$];
    logic       ok = 1'b1;
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) q[3].push_back({i == 3, 8'(8'h70 + i)});
    apply();
    wait_got(2, 20);
    hold[3] = 1'b1;
    q[0].push_back({1'b1, 8'h80});
    apply();
    repeat (5) begin
      @(negedge clk);
      if (gnt1 !== 4'b1000 || mv1 !== 1'b0 || rdy1[0] !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok || got.size() != 2) $display("FAIL gap_hold: got ok=%0b bytes=%0d, expected ok=1 bytes=2", ok, got.size());
    else pass++;
    hold[3] = 1'b0;
    apply();
    wait_got(5, 30);
    exp = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h80};
    check_bytes("gap", exp);
    total++;
    if (gots[4] !== 4'b0001) $display("FAIL gap_next_gnt: got %b, expected 0001", gots[4]);
    else pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    mrdy  = 1'b1;
    apply();
    test_reset();
    test_single();
    test_round_robin();
    test_truncate();
    test_backpressure();
    test_mid_reset();
    test_gap_no_header();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
